// File: rtl/mux_scan_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mux_scan_sequencer
// Description : Control stage for an 8-to-1 bit mux. It accepts a byte over a
//               valid/ready handshake, holds it on the mux data input, and
//               walks the three select lines through all eight positions. Each
//               position is held for CYCLES_PER_BIT clocks. The module flags
//               valid bit periods, marks the last bit, and pulses done after
//               the final bit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   CYCLES_PER_BIT : clocks per select value, legal range 1..16
//   MSB_FIRST      : 0 = index 0..7, 1 = index 7..0
// Ports
//   clock          in   sole clock, rising edge
//   reset          in   synchronous, active-low
//   io_load_valid  in   upstream offers io_load_data
//   io_load_ready  out  sequencer can accept a word (IDLE and reset high)
//   io_load_data   in   [7:0] word to serialize
//   io_abort       in   cancel the scan in progress (SHIFT only)
//   io_in          out  [7:0] held word, drives the mux data input
//   io_s0..io_s2   out  select lines, {s2,s1,s0} = current index
//   io_bit_valid   out  mux output is a valid data bit this cycle
//   io_last        out  current bit period is the final index
//   io_done        out  one-cycle pulse after the final bit period
//------------------------------------------------------------------------------
module mux_scan_sequencer #(
  parameter int CYCLES_PER_BIT = 1,
  parameter bit MSB_FIRST      = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_load_valid,
  output logic       io_load_ready,
  input  logic [7:0] io_load_data,
  input  logic       io_abort,
  output logic [7:0] io_in,
  output logic       io_s0,
  output logic       io_s1,
  output logic       io_s2,
  output logic       io_bit_valid,
  output logic       io_last,
  output logic       io_done
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  localparam logic [3:0] c_DIV_LAST  = 4'(CYCLES_PER_BIT - 1);
  localparam logic [2:0] c_IDX_FIRST = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] c_IDX_LAST  = MSB_FIRST ? 3'd0 : 3'd7;

  logic [1:0] r_state;
  logic [2:0] r_index;
  logic [3:0] r_div;
  logic [7:0] r_data;

  logic       w_div_term;
  logic       w_idx_last;
  logic [2:0] w_idx_next;

  assign w_div_term = (r_div == c_DIV_LAST);
  assign w_idx_last = (r_index == c_IDX_LAST);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_idx_next = r_index - 3'd1;
    end else begin : g_lsb_first
      assign w_idx_next = r_index + 3'd1;
    end
  endgenerate

  // Ready is the only output that sees an input directly: it must drop in
  // the same cycle reset goes low.
  assign io_load_ready = (r_state == c_IDLE) && reset;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= c_IDLE;
      r_index <= 3'd0;
      r_div   <= 4'd0;
      r_data  <= 8'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (io_load_valid && io_load_ready) begin
            r_data  <= io_load_data;
            r_index <= c_IDX_FIRST;
            r_div   <= 4'd0;
            r_state <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          // Abort takes priority over the final terminal count.
          if (io_abort) begin
            r_state <= c_IDLE;
            r_index <= 3'd0;
            r_div   <= 4'd0;
          end else if (w_div_term) begin
            r_div <= 4'd0;
            if (w_idx_last) begin
              r_state <= c_DONE;
              r_index <= 3'd0;
            end else begin
              r_index <= w_idx_next;
            end
          end else begin
            r_div <= r_div + 4'd1;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
          r_index <= 3'd0;
          r_div   <= 4'd0;
        end
      endcase
    end
  end

  assign io_in        = r_data;
  assign io_s0        = r_index[0];
  assign io_s1        = r_index[1];
  assign io_s2        = r_index[2];
  assign io_bit_valid = (r_state == c_SHIFT);
  assign io_last      = (r_state == c_SHIFT) && w_idx_last;
  assign io_done      = (r_state == c_DONE);

endmodule
`default_nettype wire
